// File: rtl/uart_fifo_tx_if.sv
// uart_fifo_tx_if: read side of the TX FIFO as seen by the UART transmitter.
// Signals: fifo_empty (FIFO empty flag), fifo_data (head word), fifo_rd (pop strobe).
// Modports: master = transmitter (pops words), slave = FIFO (supplies them).
interface uart_fifo_tx_if #(
   parameter int DBIT = 8
);
   logic            fifo_empty;
   logic [DBIT-1:0] fifo_data;
   logic            fifo_rd;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd
   );
endinterface

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops one FIFO word per frame and sends it LSB-first with start,
// optional parity and stop bits, timed by a 16x oversampling baud tick.
// Ports: clk, reset (async, active-low), s_tick (baud tick),
//   fifo (uart_fifo_tx_if.master: fifo_empty/fifo_data in, fifo_rd out),
//   tx (serial line, idles high), tx_busy (not idle), tx_done (frame end pulse).
module uart_fifo_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int PARITY  = 0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           s_tick,
   uart_fifo_tx_if.master fifo,
   output logic           tx,
   output logic           tx_busy,
   output logic           tx_done
);

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic [4:0] S_LAST  = 5'd15;
   localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
   localparam logic       ODD     = (PARITY == 2);
   localparam logic       HAS_PAR = (PARITY != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [4:0]      s;
   logic [4:0]      s_n;
   logic [NW-1:0]   n;
   logic [NW-1:0]   n_n;
   logic [DBIT-1:0] sh;
   logic [DBIT-1:0] sh_n;
   logic            par;
   logic            par_n;
   logic            tx_n;
   logic            rd_n;
   logic            done_n;
   logic            rd_q;

   // State and registered outputs; reset drops an in-flight frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         s       <= '0;
         n       <= '0;
         sh      <= '0;
         par     <= 1'b0;
         tx      <= 1'b1;
         rd_q    <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state   <= state_n;
         s       <= s_n;
         n       <= n_n;
         sh      <= sh_n;
         par     <= par_n;
         tx      <= tx_n;
         rd_q    <= rd_n;
         tx_done <= done_n;
      end
   end

   // Next-state logic; the tick is only honoured outside IDLE.
   always_comb begin
      state_n = state;
      s_n     = s;
      n_n     = n;
      sh_n    = sh;
      par_n   = par;
      unique case (state)
         IDLE: begin
            if (!fifo.fifo_empty) begin
               sh_n    = fifo.fifo_data;
               par_n   = (^fifo.fifo_data) ^ ODD;
               s_n     = '0;
               state_n = START;
            end
         end
         START: begin
            if (s_tick) begin
               if (s == S_LAST) begin
                  s_n     = '0;
                  n_n     = '0;
                  state_n = DATA;
               end else begin
                  s_n = s + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s == S_LAST) begin
                  s_n  = '0;
                  sh_n = sh >> 1;
                  if (n == N_LAST) begin
                     state_n = HAS_PAR ? PAR : STOP;
                  end else begin
                     n_n = n + 1'b1;
                  end
               end else begin
                  s_n = s + 5'd1;
               end
            end
         end
         PAR: begin
            if (s_tick) begin
               if (s == S_LAST) begin
                  s_n     = '0;
                  state_n = STOP;
               end else begin
                  s_n = s + 5'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s == SB_LAST) begin
                  s_n     = '0;
                  state_n = IDLE;
               end else begin
                  s_n = s + 5'd1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // tx follows the next state so the line moves on the same edge.
   always_comb begin
      tx_n = 1'b1;
      unique case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = sh_n[0];
         PAR:     tx_n = par_n;
         default: tx_n = 1'b1;
      endcase
      rd_n   = (state == IDLE) && (state_n == START);
      done_n = (state == STOP) && (state_n == IDLE);
   end

   assign fifo.fifo_rd = rd_q;
   assign tx_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: table vectors, hand sequences and random streams for
// uart_fifo_tx, checked against a frame-level model of the serial line.
module tb_uart_fifo_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] tick;
   wire  [2:0] txv;
   wire  [2:0] busyv;
   wire  [2:0] donev;
   wire  [2:0] rdv;

   uart_fifo_tx_if #(.DBIT(8)) f0 ();
   uart_fifo_tx_if #(.DBIT(8)) f1 ();
   uart_fifo_tx_if #(.DBIT(8)) f2 ();

   uart_fifo_tx d0 (
      .clk(clk), .reset(reset), .s_tick(tick[0]), .fifo(f0),
      .tx(txv[0]), .tx_busy(busyv[0]), .tx_done(donev[0])
   );

   uart_fifo_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) d1 (
      .clk(clk), .reset(reset), .s_tick(tick[1]), .fifo(f1),
      .tx(txv[1]), .tx_busy(busyv[1]), .tx_done(donev[1])
   );

   uart_fifo_tx #(.DBIT(8), .SB_TICK(32), .PARITY(2)) d2 (
      .clk(clk), .reset(reset), .s_tick(tick[2]), .fifo(f2),
      .tx(txv[2]), .tx_busy(busyv[2]), .tx_done(donev[2])
   );

   always #5 clk = ~clk;

   // FIFO models, one per DUT
   logic [7:0] mem [3][64];
   int wp [3] = '{0, 0, 0};
   int rp [3] = '{0, 0, 0};

   assign f0.fifo_empty = (wp[0] == rp[0]);
   assign f1.fifo_empty = (wp[1] == rp[1]);
   assign f2.fifo_empty = (wp[2] == rp[2]);
   assign f0.fifo_data  = mem[0][rp[0][5:0]];
   assign f1.fifo_data  = mem[1][rp[1][5:0]];
   assign f2.fifo_data  = mem[2][rp[2][5:0]];
   assign rdv[0] = f0.fifo_rd;
   assign rdv[1] = f1.fifo_rd;
   assign rdv[2] = f2.fifo_rd;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++)
         if (rdv[i]) rp[i] <= rp[i] + 1;
   end

   int pm [3] = '{0, 1, 2};
   int sb [3] = '{16, 16, 32};
   int per [3] = '{1, 1, 1};
   int tc [3] = '{0, 0, 0};

   int total = 0;
   int bad = 0;

   logic [2:0] s_tx, s_busy, s_done, s_rd;
   bit ctx [4096];
   bit cbusy [4096];
   bit crd [4096];
   bit cdone [4096];
   logic [7:0] sbytes [8];

   typedef struct {
      int         dut;
      logic [7:0] d;
      int         pbit;
      int         len;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Sample outputs, then set ticks for the next rising edge.
   task automatic step();
      @(negedge clk);
      s_tx   = txv;
      s_busy = busyv;
      s_done = donev;
      s_rd   = rdv;
      for (int i = 0; i < 3; i++) begin
         if (per[i] == 0) begin
            tick[i] = 1'b0;
         end else begin
            tc[i]   = (tc[i] + 1) % per[i];
            tick[i] = (tc[i] == 0);
         end
      end
   endtask

   task automatic push(input int idx, input logic [7:0] d);
      mem[idx][wp[idx][5:0]] = d;
      wp[idx] = wp[idx] + 1;
   endtask

   // Expected tx r clocks after the start edge, one tick per clock.
   function automatic bit model_tx(input logic [7:0] d, input int p,
                                   input int r);
      int slot;
      slot = r / 16;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return d[slot-1];
      if (p != 0 && slot == 9) return (^d) ^ (p == 2);
      return 1'b1;
   endfunction

   function automatic int flen(input int p, input int sbt);
      return 16 * (1 + 8 + ((p != 0) ? 1 : 0)) + sbt;
   endfunction

   // Wait for the pop strobe (sample 0), then record nsamp samples.
   // Ticks are held off for fz_len clocks starting after sample fz_at.
   task automatic capture(input int idx, input int nsamp, input int fz_at,
                          input int fz_len, output bit got);
      int sv;
      got = 1'b0;
      sv  = per[idx];
      for (int w = 0; w < 400; w++) begin
         step();
         if (s_rd[idx]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("start_timeout", 0, 1);
         return;
      end
      for (int k = 0; k < nsamp; k++) begin
         if (k > 0) begin
            if (k == fz_at) per[idx] = 0;
            if (k == fz_at + fz_len) per[idx] = sv;
            step();
         end
         ctx[k]   = s_tx[idx];
         cbusy[k] = s_busy[idx];
         crd[k]   = s_rd[idx];
         cdone[k] = s_done[idx];
      end
      per[idx] = sv;
   endtask

   task automatic stream(input int idx, input int nb, input string nm);
      int L, tot, j, r, ew, er, ed, eb;
      bit got;
      L = flen(pm[idx], sb[idx]);
      tot = nb * (L + 1);
      for (int q = 0; q < nb; q++) push(idx, sbytes[q]);
      capture(idx, tot, -1, 0, got);
      if (got) begin
         ew = 0; er = 0; ed = 0; eb = 0;
         for (int k = 0; k < tot; k++) begin
            j = k / (L + 1);
            r = k % (L + 1);
            if (ctx[k] != ((r == L) ? 1'b1 : model_tx(sbytes[j], pm[idx], r)))
               ew++;
            if (crd[k] != (r == 0)) er++;
            if (cdone[k] != (r == L)) ed++;
            if (cbusy[k] != (r < L)) eb++;
         end
         chk({nm, "_tx_err"}, ew, 0);
         chk({nm, "_rd_err"}, er, 0);
         chk({nm, "_done_err"}, ed, 0);
         chk({nm, "_busy_err"}, eb, 0);
      end
   endtask

   initial begin
      bit got;
      int dk, bw, bb, nrd, t0, ew, de, e, q;
      logic exp_b;

      tbl[0] = '{0, 8'h55, -1, 160};
      tbl[1] = '{1, 8'h07,  1, 176};
      tbl[2] = '{2, 8'h07,  0, 192};
      tbl[3] = '{1, 8'h00,  0, 176};
      tbl[4] = '{0, 8'hA3, -1, 160};
      tbl[5] = '{2, 8'h80,  0, 192};
      tbl[6] = '{1, 8'hFF,  0, 176};

      tick  = 3'b111;
      reset = 1'b0;
      repeat (3) step();
      chk("rst_tx", int'(s_tx), 7);
      chk("rst_busy", int'(s_busy), 0);
      chk("rst_rd", int'(s_rd), 0);
      chk("rst_done", int'(s_done), 0);
      reset = 1'b1;
      repeat (2) step();

      // table vectors: one frame each
      for (int t = 0; t < 7; t++) begin
         push(tbl[t].dut, tbl[t].d);
         capture(tbl[t].dut, tbl[t].len + 2, -1, 0, got);
         if (got) begin
            dk = -1; bw = 0; bb = 0; nrd = 0;
            for (int k = 0; k < tbl[t].len + 2; k++) begin
               if (cdone[k] && dk < 0) dk = k;
               if (crd[k]) nrd++;
            end
            for (int k = 0; k < tbl[t].len; k++) begin
               if (ctx[k] != model_tx(tbl[t].d, pm[tbl[t].dut], k)) bw++;
               if (!cbusy[k]) bb++;
            end
            if (cbusy[tbl[t].len]) bb++;
            chk($sformatf("v%0d_len", t), dk, tbl[t].len);
            chk($sformatf("v%0d_wave_err", t), bw, 0);
            chk($sformatf("v%0d_busy_err", t), bb, 0);
            chk($sformatf("v%0d_rd_cnt", t), nrd, 1);
            if (tbl[t].pbit >= 0)
               chk($sformatf("v%0d_par", t), int'(ctx[152]), tbl[t].pbit);
         end
         repeat (3) step();
      end

      // back-to-back, then random streams
      sbytes[0] = 8'hA3;
      sbytes[1] = 8'h0F;
      stream(0, 2, "b2b");
      repeat (3) step();
      for (int i = 0; i < 4; i++) sbytes[i] = 8'($urandom_range(0, 255));
      stream(0, 4, "rnd0");
      repeat (3) step();
      for (int i = 0; i < 4; i++) sbytes[i] = 8'($urandom_range(0, 255));
      stream(1, 4, "rnd1");
      repeat (3) step();

      // tick every 4 clks, 2 stop bits, odd parity
      for (int f = 0; f < 2; f++) begin
         per[2] = 4;
         sbytes[0] = (f == 0) ? 8'h55 : 8'hB5;
         push(2, sbytes[0]);
         capture(2, 1000, (f == 0) ? -1 : 266, 100, got);
         if (got) begin
            t0 = -1;
            for (int k = 1; k < 200; k++)
               if (ctx[k] && t0 < 0) t0 = k;
            chk($sformatf("slow%0d_start_ok", f),
                int'(t0 >= 61 && t0 <= 64), 1);
            if (t0 < 0) t0 = 64;
            e = (f == 0) ? 0 : 100;
            ew = 0;
            de = -1;
            for (int k = 0; k < 1000; k++) begin
               if (cdone[k] && de < 0) de = k;
               if (f == 1 && k > 266 && k <= 366) q = 266;
               else if (f == 1 && k > 366) q = k - 100;
               else q = k;
               if (q < t0) exp_b = 1'b0;
               else exp_b = model_tx(sbytes[0], 2, 16 + (q - t0) / 4);
               if (k < t0 + 704 + e && ctx[k] != exp_b) ew++;
               if (k < t0 + 704 + e && !cbusy[k]) ew++;
            end
            chk($sformatf("slow%0d_wave_err", f), ew, 0);
            chk($sformatf("slow%0d_done_at", f), de, t0 + 704 + e);
         end
         repeat (3) step();
      end
      per[2] = 1;

      // reset during data bit 3 of 0xFF; 0x3C must follow intact
      push(0, 8'hFF);
      push(0, 8'h3C);
      capture(0, 70, -1, 0, got);
      reset = 1'b0;
      #1;
      chk("mid_rst_tx", int'(txv[0]), 1);
      chk("mid_rst_busy", int'(busyv[0]), 0);
      chk("mid_rst_rd_done", int'({rdv[0], donev[0]}), 0);
      repeat (3) step();
      reset = 1'b1;
      capture(0, 162, -1, 0, got);
      if (got) begin
         bw = 0;
         dk = -1;
         for (int k = 0; k < 162; k++) begin
            if (k < 160 && ctx[k] != model_tx(8'h3C, 0, k)) bw++;
            if (cdone[k] && dk < 0) dk = k;
         end
         chk("post_rst_wave_err", bw, 0);
         chk("post_rst_len", dk, 160);
      end
      repeat (3) step();

      // empty FIFO with ticks toggling
      per = '{2, 2, 2};
      bw = 0; bb = 0; nrd = 0; dk = 0;
      for (int k = 0; k < 1000; k++) begin
         step();
         if (s_tx != 3'b111) bw++;
         if (s_rd != 3'b000) nrd++;
         if (s_busy != 3'b000) bb++;
         if (s_done != 3'b000) dk++;
      end
      chk("empty_tx_err", bw, 0);
      chk("empty_rd_err", nrd, 0);
      chk("empty_busy_err", bb, 0);
      chk("empty_done_err", dk, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
